pc_sequencer: RTL and testbench

//  Next-PC sequencer and fetch controller for the single-cycle/fetch front end.
//  - Drives npc into the PC register; the PC register loads npc on every clk.
//  - Runs the instruction-memory request/ack handshake.
//  - Arbitrates redirect sources: exception, eret, jr, j, branch and sequential.
//  - Buffers a redirect that arrives while a fetch is in flight, and holds PC during pipeline stalls.

---
 rtl/pc_sequencer.sv | 144 ++++++++++++++
 tb/tb_pc_sequencer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Next-PC sequencer and instruction-fetch controller: redirect arbitration,
// imem request/ack handshake, redirect buffering across in-flight fetches and stall hold.
module pc_sequencer #(
    parameter logic [31:0] RESET_VEC = 32'h0000_3000,
    parameter logic [31:0] EXC_VEC   = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    input  logic        imem_ack,
    input  logic        stall,
    input  logic        exc_valid,
    input  logic        eret_valid,
    input  logic [31:0] epc,
    input  logic        jr_valid,
    input  logic [31:0] jr_target,
    input  logic        j_valid,
    input  logic [31:0] j_target,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic [31:0] npc,
    output logic        imem_req,
    output logic        inst_valid,
    output logic        redir_pend,
    output logic        addr_err
);

    // state | meaning
    // BOOT  | first cycle after reset, no fetch issued yet
    // REQ   | fetch for pc outstanding, waiting on imem_ack
    // HOLD  | instruction fetched but downstream stalled; PC frozen
    typedef enum logic [1:0] {
        BOOT = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic        pend_v;
    logic        pend_v_nx;
    logic [31:0] pend_tgt;
    logic [31:0] pend_tgt_nx;
    logic        pend_exc;
    logic        pend_exc_nx;

    logic        redir;
    logic [31:0] tgt;
    logic        apply;
    logic [31:0] app_raw;
    logic        keep_exc;

    always_comb begin
        redir = exc_valid | eret_valid | jr_valid | j_valid | br_taken;
        tgt   = '0;
        if (exc_valid)       tgt = EXC_VEC;
        else if (eret_valid) tgt = epc;
        else if (jr_valid)   tgt = jr_target;
        else if (j_valid)    tgt = j_target;
        else if (br_taken)   tgt = br_target;
    end

    // A buffered exception wins over any newer, lower-priority redirect.
    assign keep_exc = pend_v && pend_exc && !exc_valid;

    always_comb begin
        npc         = pc;
        imem_req    = 1'b0;
        inst_valid  = 1'b0;
        addr_err    = 1'b0;
        apply       = 1'b0;
        app_raw     = '0;
        state_nx    = state;
        pend_v_nx   = pend_v;
        pend_tgt_nx = pend_tgt;
        pend_exc_nx = pend_exc;
        if (rst) begin
            npc = RESET_VEC;
        end else begin
            case (state)
                BOOT: begin
                    state_nx = REQ;
                    if (redir) begin
                        apply   = 1'b1;
                        app_raw = tgt;
                    end
                end
                REQ: begin
                    imem_req = 1'b1;
                    if (!imem_ack) begin
                        if (redir && !keep_exc) begin
                            pend_v_nx   = 1'b1;
                            pend_tgt_nx = tgt;
                            pend_exc_nx = exc_valid;
                        end
                    end else if (pend_v || redir) begin
                        apply       = 1'b1;
                        app_raw     = (redir && !keep_exc) ? tgt : pend_tgt;
                        pend_v_nx   = 1'b0;
                        pend_exc_nx = 1'b0;
                    end else if (!stall) begin
                        inst_valid = 1'b1;
                        npc        = pc + 32'd4;
                    end else begin
                        state_nx = HOLD;
                    end
                end
                HOLD: begin
                    if (redir) begin
                        apply    = 1'b1;
                        app_raw  = tgt;
                        state_nx = REQ;
                    end else if (!stall) begin
                        inst_valid = 1'b1;
                        npc        = pc + 32'd4;
                        state_nx   = REQ;
                    end
                end
                default: state_nx = BOOT;
            endcase
        end
        if (apply) begin
            npc      = {app_raw[31:2], 2'b00};
            addr_err = |app_raw[1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= BOOT;
            pend_v   <= 1'b0;
            pend_tgt <= '0;
            pend_exc <= 1'b0;
        end else begin
            state    <= state_nx;
            pend_v   <= pend_v_nx;
            pend_tgt <= pend_tgt_nx;
            pend_exc <= pend_exc_nx;
        end
    end

    assign redir_pend = pend_v && !rst;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed + randomized bench for pc_sequencer; the bench plays the PC register
// and compares every output each cycle against a behavioural model.
module tb_pc_sequencer;

    localparam logic [31:0] RESET_VEC = 32'h0000_3000;
    localparam logic [31:0] EXC_VEC   = 32'h0000_4180;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic        imem_ack, stall;
    logic        exc_valid, eret_valid, jr_valid, j_valid, br_taken;
    logic [31:0] epc, jr_target, j_target, br_target;
    logic [31:0] npc;
    logic        imem_req, inst_valid, redir_pend, addr_err;

    pc_sequencer #(.RESET_VEC(RESET_VEC), .EXC_VEC(EXC_VEC)) dut (
        .clk(clk), .rst(rst), .pc(pc), .imem_ack(imem_ack), .stall(stall),
        .exc_valid(exc_valid), .eret_valid(eret_valid), .epc(epc),
        .jr_valid(jr_valid), .jr_target(jr_target), .j_valid(j_valid), .j_target(j_target),
        .br_taken(br_taken), .br_target(br_target),
        .npc(npc), .imem_req(imem_req), .inst_valid(inst_valid),
        .redir_pend(redir_pend), .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [31:0] tgt;
        logic        exc;
    } pend_t;

    // model: the fetch front end is either just out of reset, waiting on
    // a stalled consumer, or waiting for the memory; plus a one-deep redirect buffer
    logic [31:0] m_pc = '0;
    bit          m_booting = 1'b1;
    bit          m_holding = 1'b0;
    pend_t       pend_q[$];
    bit          nx_booting, nx_holding;
    pend_t       nx_q[$];
    logic [31:0] e_npc;
    logic        e_req, e_iv, e_pend, e_err;

    task automatic model_eval();
        logic        cv[5];
        logic [31:0] cand[5];
        logic [31:0] sel;
        logic [31:0] raw;
        bit          any;
        bit          take;
        cv   = '{exc_valid, eret_valid, jr_valid, j_valid, br_taken};
        cand = '{EXC_VEC, epc, jr_target, j_target, br_target};
        any  = 1'b0;
        sel  = '0;
        for (int i = 4; i >= 0; i--) if (cv[i]) begin sel = cand[i]; any = 1'b1; end
        nx_booting = m_booting;
        nx_holding = m_holding;
        nx_q       = pend_q;
        e_npc = m_pc; e_req = 1'b0; e_iv = 1'b0; e_err = 1'b0;
        e_pend = (pend_q.size() != 0) && !rst;
        take = 1'b0; raw = '0;
        if (rst) begin
            e_npc = RESET_VEC;
            nx_booting = 1'b1; nx_holding = 1'b0; nx_q.delete();
        end else if (m_booting) begin
            nx_booting = 1'b0;
            if (any) begin take = 1'b1; raw = sel; end
        end else if (m_holding) begin
            if (any) begin take = 1'b1; raw = sel; nx_holding = 1'b0; end
            else if (!stall) begin e_iv = 1'b1; e_npc = m_pc + 32'd4; nx_holding = 1'b0; end
        end else begin
            e_req = 1'b1;
            if (!imem_ack) begin
                if (any && (nx_q.size() == 0 || exc_valid || !nx_q[0].exc)) begin
                    nx_q.delete();
                    nx_q.push_back('{tgt: sel, exc: exc_valid});
                end
            end else if (any || pend_q.size() != 0) begin
                take = 1'b1;
                if (pend_q.size() != 0 && pend_q[0].exc && !exc_valid) raw = pend_q[0].tgt;
                else if (any) raw = sel;
                else raw = pend_q[0].tgt;
                nx_q.delete();
            end else if (!stall) begin
                e_iv = 1'b1; e_npc = m_pc + 32'd4;
            end else begin
                nx_holding = 1'b1;
            end
        end
        if (take) begin
            e_npc = raw & 32'hFFFF_FFFC;
            e_err = (raw % 4) != 0;
        end
    endtask

    task automatic model_commit();
        m_booting = nx_booting;
        m_holding = nx_holding;
        pend_q    = nx_q;
        m_pc      = e_npc;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clr_in();
        rst = 1'b0; imem_ack = 1'b0; stall = 1'b0;
        exc_valid = 1'b0; eret_valid = 1'b0; jr_valid = 1'b0; j_valid = 1'b0; br_taken = 1'b0;
        epc = '0; jr_target = '0; j_target = '0; br_target = '0;
    endtask

    // one clock: inputs already set, checked mid-cycle, model advanced at the edge
    task automatic step(input bit lit_en = 1'b0, input logic [31:0] lit_npc = '0,
                        input bit lit_pend_en = 1'b0, input logic lit_pend = 1'b0);
        pc = m_pc;
        #4;
        model_eval();
        chk("npc", npc, e_npc);
        chk("imem_req", 32'(imem_req), 32'(e_req));
        chk("inst_valid", 32'(inst_valid), 32'(e_iv));
        chk("redir_pend", 32'(redir_pend), 32'(e_pend));
        chk("addr_err", 32'(addr_err), 32'(e_err));
        if (lit_en) chk("npc_directed", npc, lit_npc);
        if (lit_pend_en) chk("redir_pend_directed", 32'(redir_pend), 32'(lit_pend));
        @(posedge clk);
        model_commit();
        #1;
    endtask

    initial begin
        clr_in();
        pc = '0;
        @(posedge clk); #1;
        // reset
        rst = 1'b1; step(1'b1, 32'h3000); step(1'b1, 32'h3000);
        clr_in(); step(1'b1, 32'h3000);                 // BOOT
        // sequential fetch
        imem_ack = 1'b1;
        step(1'b1, 32'h3004); step(1'b1, 32'h3008); step(1'b1, 32'h300C);
        // priority
        exc_valid = 1'b1; jr_valid = 1'b1; jr_target = 32'h3400; br_taken = 1'b1; br_target = 32'h3100;
        step(1'b1, 32'h4180);
        // pending redirect across an outstanding fetch
        clr_in(); j_valid = 1'b1; j_target = 32'h3800;
        step(1'b0, '0, 1'b1, 1'b0);
        clr_in(); step(1'b0, '0, 1'b1, 1'b1); step(1'b0, '0, 1'b1, 1'b1);
        imem_ack = 1'b1; step(1'b1, 32'h3800, 1'b1, 1'b1);
        clr_in(); step(1'b0, '0, 1'b1, 1'b0);
        // stall hold at 0x3010
        imem_ack = 1'b1; br_taken = 1'b1; br_target = 32'h3010; step(1'b1, 32'h3010);
        clr_in(); imem_ack = 1'b1; stall = 1'b1; step(1'b1, 32'h3010);
        step(1'b1, 32'h3010);
        stall = 1'b0; step(1'b1, 32'h3014);
        // misaligned target and wrap
        imem_ack = 1'b1; br_taken = 1'b1; br_target = 32'h3102; step(1'b1, 32'h3100);
        clr_in(); imem_ack = 1'b1; j_valid = 1'b1; j_target = 32'hFFFF_FFFC; step(1'b1, 32'hFFFF_FFFC);
        clr_in(); imem_ack = 1'b1; step(1'b1, 32'h0000_0000);
        // buffered exception survives a later jump
        clr_in(); exc_valid = 1'b1; step();
        clr_in(); j_valid = 1'b1; j_target = 32'h5000; step();
        clr_in(); imem_ack = 1'b1; j_valid = 1'b1; j_target = 32'h5004; step(1'b1, 32'h4180);
        // reset while a redirect is buffered
        clr_in(); jr_valid = 1'b1; jr_target = 32'h6000; step();
        clr_in(); rst = 1'b1; step(1'b1, 32'h3000, 1'b1, 1'b0);
        clr_in(); step();
        // randomized traffic
        for (int c = 0; c < 600; c++) begin
            clr_in();
            rst        = ($urandom % 50) == 0;
            imem_ack   = ($urandom % 3) != 0;
            stall      = ($urandom % 4) == 0;
            exc_valid  = ($urandom % 16) == 0;
            eret_valid = ($urandom % 12) == 0;
            jr_valid   = ($urandom % 10) == 0;
            j_valid    = ($urandom % 10) == 0;
            br_taken   = ($urandom % 8) == 0;
            epc        = $urandom & (($urandom % 4) == 0 ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
            jr_target  = $urandom & (($urandom % 4) == 0 ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
            j_target   = $urandom & (($urandom % 4) == 0 ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
            br_target  = $urandom & (($urandom % 4) == 0 ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
            step();
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
